// File: rtl/s3g_tx_pkg.sv
// rtl/s3g_tx_pkg.sv - shared S3G link constants, state encoding and CRC8 step function
package s3g_tx_pkg;

    // Frame start byte, shared with the receive parser.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hD5;

    // CRC-8 generator x^8 + x^2 + x + 1, MSB first, zero seed.
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CRC  = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    // One payload byte folded into the running CRC, data bit 7 first.
    function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data, input logic [7:0] crc);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_tx.sv
// rtl/s3g_tx.sv - S3G transmit framer: sync, length, payload, CRC8 to the UART
module s3g_tx
    import s3g_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] payload_len,
    output logic [7:0] buffer_addr,
    input  logic [7:0] buffer_data,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    output logic       busy,
    output logic       done
);

    // The byte-issuing states (SYNC/LEN/DATA/CRC) last exactly one cycle and
    // are the cycles in which tx_wr is high. Their register updates are made on
    // the edge that enters them, so a write appears the cycle right after the
    // start request or the tx_done that released the previous byte.

    state_t     state_q, state_d;
    state_t     kind_q, kind_d;
    logic [7:0] len_q, len_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_wr_q, tx_wr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       enter;

    // State register and the WAIT return target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kind_q  <= S_IDLE;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    // Next-state logic: each issuing state parks in WAIT until the UART
    // reports the byte finished; the done cycle blocks a back-to-back start.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                state_d = S_WAIT;
                kind_d  = S_LEN;
            end
            S_LEN: begin
                state_d = S_WAIT;
                kind_d  = (len_q != 8'd0) ? S_DATA : S_CRC;
            end
            S_DATA: begin
                // byte_cnt_q was already decremented on entry to this byte.
                state_d = S_WAIT;
                kind_d  = (byte_cnt_q != 8'd0) ? S_DATA : S_CRC;
            end
            S_CRC: begin
                state_d = S_WAIT;
                kind_d  = S_IDLE;
            end
            S_WAIT: begin
                if (tx_done) begin
                    state_d = kind_q;
                    done_d  = (kind_q == S_IDLE);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign enter = (state_d != state_q);

    // Output/datapath next values, computed for the state being entered.
    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        if (enter) begin
            case (state_d)
                S_SYNC: begin
                    // Accepting start also prefetches payload byte 0.
                    len_d      = payload_len;
                    byte_cnt_d = payload_len;
                    crc_d      = 8'h00;
                    addr_d     = 8'h00;
                    tx_data_d  = SYNC_BYTE;
                    tx_wr_d    = 1'b1;
                end
                S_LEN: begin
                    tx_data_d = len_q;
                    tx_wr_d   = 1'b1;
                end
                S_DATA: begin
                    // buffer_data reflects addr_q, set when the previous byte
                    // went out, so it has long settled by now.
                    tx_data_d  = buffer_data;
                    tx_wr_d    = 1'b1;
                    crc_d      = nextCRC8_D8(buffer_data, crc_q);
                    addr_d     = addr_q + 8'd1;
                    byte_cnt_d = byte_cnt_q - 8'd1;
                end
                S_CRC: begin
                    tx_data_d = crc_q;
                    tx_wr_d   = 1'b1;
                end
                default: begin
                end
            endcase
        end
        busy_d = (state_d != S_IDLE) || done_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= 8'h00;
            byte_cnt_q <= 8'h00;
            crc_q      <= 8'h00;
            addr_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign buffer_addr = addr_q;
    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
